fetch_pc_stage: RTL and testbench

- PC generation plus IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the ID-stage branch bubble and hazard logic.
- Consumes BranchBubble and the load-use stall to freeze fetch.
- Takes ID-resolved branch and jump redirects and late flush requests from later stages.
- Presents id_Instr, id_PC4 and id_Valid to ID.

---
 rtl/fetch_pc_stage.sv | 101 ++++++++++
 tb/tb_fetch_pc_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: PC generation and IF/ID pipeline register of the 5-stage MIPS pipeline.
//
// Ports:
//   clk            pipeline clock, rising edge
//   rst_n          asynchronous active-low reset
//   BranchBubble   stall request from ID branch hazard logic
//   LoadUseStall   stall request from load-use hazard logic
//   redirect_valid ID resolved a taken branch/jump this cycle
//   redirect_pc    redirect target (bits [1:0] forced to 00)
//   flush_valid    late flush (exception/ERET) from MEM
//   flush_pc       flush target (bits [1:0] forced to 00)
//   imem_addr      instruction memory address (= PC register)
//   imem_rdata     instruction word, asynchronous read of imem_addr
//   id_Instr       IF/ID instruction (0 = NOP bubble)
//   id_PC4         IF/ID PC+4 of that instruction
//   id_Valid       IF/ID entry holds a real instruction
//   stall_timeout  sticky stall watchdog flag
//
// Optional feature: define STALL_WATCHDOG_EN to build the stall watchdog;
// without it stall_timeout is tied to 0.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned DELAY_SLOT = 1,
    parameter int unsigned WDOG_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BranchBubble,
    input  logic        LoadUseStall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_Instr,
    output logic [31:0] id_PC4,
    output logic        id_Valid,
    output logic        stall_timeout
);
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        stall;

    assign stall     = BranchBubble | LoadUseStall;
    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;

    // The 6-bit watchdog counter can only reach limits in 1..63.
    if (WDOG_LIMIT < 1 || WDOG_LIMIT > 63) begin : g_bad_limit
        $error("WDOG_LIMIT must be within 1..63");
    end

    // Flush beats stall beats redirect; a stalled redirect is re-presented later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            id_Instr <= 32'd0;
            id_PC4   <= 32'd0;
            id_Valid <= 1'b0;
        end else if (flush_valid) begin
            pc       <= flush_pc & ~32'd3;
            id_Instr <= 32'd0;
            id_PC4   <= 32'd0;
            id_Valid <= 1'b0;
        end else if (!stall) begin
            pc       <= redirect_valid ? (redirect_pc & ~32'd3) : pc4;
            id_PC4   <= pc4;
            // Without a delay slot the instruction fetched alongside the redirect is squashed.
            id_Valid <= !redirect_valid || (DELAY_SLOT != 0);
            id_Instr <= (!redirect_valid || (DELAY_SLOT != 0)) ? imem_rdata : 32'd0;
        end
    end

`ifdef STALL_WATCHDOG_EN
    logic [5:0] wdog_cnt;
    logic [5:0] wdog_next;

    // Flush edges neither count nor clear while a stall is requested.
    always_comb begin
        wdog_next = wdog_cnt;
        if (!stall)
            wdog_next = 6'd0;
        else if (!flush_valid && wdog_cnt != 6'd63)
            wdog_next = wdog_cnt + 6'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt      <= 6'd0;
            stall_timeout <= 1'b0;
        end else begin
            wdog_cnt <= wdog_next;
            if ({26'd0, wdog_next} >= WDOG_LIMIT[31:0])
                stall_timeout <= 1'b1;
        end
    end
`else
    assign stall_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb_fetch_pc_stage: randomized + directed check of fetch_pc_stage (both delay-slot modes) against a behavioural model.
module tb_fetch_pc_stage;
    localparam int LIMIT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bb, lus, rv, fv;
    logic [31:0] rpc, fpc;
    logic [31:0] addr [2];
    logic [31:0] rdata [2];
    logic [31:0] instr [2];
    logic [31:0] pc4o [2];
    logic        valid [2];
    logic        to [2];

    logic [31:0] m_pc [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc4 [2];
    logic        m_valid [2];
    int          m_cnt;
    logic        m_to;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0F0F) * 32'h9E37_79B1) + 32'd7;
    endfunction

    assign rdata[0] = mem(addr[0]);
    assign rdata[1] = mem(addr[1]);

    fetch_pc_stage #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1), .WDOG_LIMIT(LIMIT)) u_ds1 (
        .clk(clk), .rst_n(rst_n), .BranchBubble(bb), .LoadUseStall(lus),
        .redirect_valid(rv), .redirect_pc(rpc), .flush_valid(fv), .flush_pc(fpc),
        .imem_addr(addr[0]), .imem_rdata(rdata[0]), .id_Instr(instr[0]),
        .id_PC4(pc4o[0]), .id_Valid(valid[0]), .stall_timeout(to[0]));

    fetch_pc_stage #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(0), .WDOG_LIMIT(LIMIT)) u_ds0 (
        .clk(clk), .rst_n(rst_n), .BranchBubble(bb), .LoadUseStall(lus),
        .redirect_valid(rv), .redirect_pc(rpc), .flush_valid(fv), .flush_pc(fpc),
        .imem_addr(addr[1]), .imem_rdata(rdata[1]), .id_Instr(instr[1]),
        .id_PC4(pc4o[1]), .id_Valid(valid[1]), .stall_timeout(to[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_to();
`ifdef STALL_WATCHDOG_EN
        return m_to;
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("imem_addr[ds%0d]", 1 - i), addr[i], m_pc[i]);
            chk($sformatf("id_Instr[ds%0d]", 1 - i), instr[i], m_instr[i]);
            chk($sformatf("id_PC4[ds%0d]", 1 - i), pc4o[i], m_pc4[i]);
            chk($sformatf("id_Valid[ds%0d]", 1 - i), {31'd0, valid[i]}, {31'd0, m_valid[i]});
            chk($sformatf("stall_timeout[ds%0d]", 1 - i), {31'd0, to[i]}, {31'd0, exp_to()});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0000_3000;
            m_instr[i] = 32'd0;
            m_pc4[i] = 32'd0;
            m_valid[i] = 1'b0;
        end
        m_cnt = 0;
        m_to = 1'b0;
    endtask

    // Index 0 keeps the delay-slot instruction, index 1 squashes it.
    task automatic model_edge();
        logic st;
        logic [31:0] nxt;
        st = bb | lus;
        for (int i = 0; i < 2; i++) begin
            nxt = m_pc[i] + 32'd4;
            if (fv) begin
                m_pc[i] = {fpc[31:2], 2'b00};
                m_instr[i] = 32'd0;
                m_pc4[i] = 32'd0;
                m_valid[i] = 1'b0;
            end else if (!st) begin
                m_instr[i] = (rv && i == 1) ? 32'd0 : mem(m_pc[i]);
                m_valid[i] = !(rv && i == 1);
                m_pc4[i] = nxt;
                m_pc[i] = rv ? {rpc[31:2], 2'b00} : nxt;
            end
        end
        if (!st) m_cnt = 0;
        else if (!fv) m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
        if (m_cnt >= LIMIT) m_to = 1'b1;
    endtask

    task automatic step(input logic b, input logic l, input logic r, input logic [31:0] rp,
                        input logic f, input logic [31:0] fp);
        bb = b; lus = l; rv = r; rpc = rp; fv = f; fpc = fp;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic free(); step(0, 0, 0, 32'd0, 0, 32'd0); endtask

    // Asynchronous reset pulse inside the low clock phase, released before the next edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bb = 0; lus = 0; rv = 0; fv = 0; rpc = '0; fpc = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        chk("lit_reset_addr", addr[0], 32'h0000_3000);
        chk("lit_reset_valid", {31'd0, valid[0]}, 32'd0);
        rst_n = 1'b1;

        free();
        chk("lit_addr_3004", addr[0], 32'h0000_3004);
        chk("lit_pc4_3004", pc4o[0], 32'h0000_3004);
        chk("lit_instr_3000", instr[0], mem(32'h0000_3000));
        chk("lit_valid_1", {31'd0, valid[0]}, 32'd1);
        free();
        chk("lit_addr_3008", addr[0], 32'h0000_3008);
        step(1, 0, 0, 32'd0, 0, 32'd0);
        step(1, 0, 0, 32'd0, 0, 32'd0);
        chk("lit_bubble_addr", addr[0], 32'h0000_3008);
        chk("lit_bubble_pc4", pc4o[0], 32'h0000_3008);
        free();
        chk("lit_resume_addr", addr[0], 32'h0000_300C);
        chk("lit_resume_pc4", pc4o[0], 32'h0000_300C);
        free();
        chk("lit_addr_3010", addr[0], 32'h0000_3010);
        step(0, 0, 1, 32'h0000_3103, 0, 32'd0);
        chk("lit_redir_addr", addr[0], 32'h0000_3100);
        chk("lit_ds1_instr", instr[0], mem(32'h0000_3010));
        chk("lit_ds1_valid", {31'd0, valid[0]}, 32'd1);
        chk("lit_ds0_instr", instr[1], 32'd0);
        chk("lit_ds0_valid", {31'd0, valid[1]}, 32'd0);
        chk("lit_ds0_pc4", pc4o[1], 32'h0000_3014);
        free();
        chk("lit_target_instr", instr[1], mem(32'h0000_3100));
        step(0, 1, 1, 32'h0000_3200, 0, 32'd0);
        chk("lit_lus_redir_hold", addr[0], 32'h0000_3104);
        step(0, 0, 1, 32'h0000_3200, 0, 32'd0);
        chk("lit_redir_taken", addr[0], 32'h0000_3200);
        step(1, 0, 0, 32'd0, 1, 32'h0000_0180);
        chk("lit_flush_addr", addr[0], 32'h0000_0180);
        chk("lit_flush_valid", {31'd0, valid[0]}, 32'd0);
        chk("lit_flush_instr", instr[0], 32'd0);
        step(0, 0, 0, 32'd0, 1, 32'hFFFF_FFFF);
        chk("lit_flush_align", addr[0], 32'hFFFF_FFFC);
        free();
        chk("lit_wrap_addr", addr[0], 32'd0);
        chk("lit_wrap_pc4", pc4o[0], 32'd0);

        do_reset();
        for (int k = 0; k < 15; k++) step(0, 1, 0, 32'd0, 0, 32'd0);
        free();
        for (int k = 0; k < 15; k++) step(0, 1, 0, 32'd0, 0, 32'd0);
        chk("lit_wdog_15_1_15", {31'd0, to[0]}, 32'd0);
        do_reset();
        for (int k = 0; k < 15; k++) step(0, 1, 0, 32'd0, 0, 32'd0);
        chk("lit_wdog_15", {31'd0, to[0]}, 32'd0);
        step(0, 1, 0, 32'd0, 0, 32'd0);
`ifdef STALL_WATCHDOG_EN
        chk("lit_wdog_16", {31'd0, to[0]}, 32'd1);
`else
        chk("lit_wdog_off", {31'd0, to[0]}, 32'd0);
`endif
        do_reset();

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(0, 3)) : $urandom;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, t,
                 $urandom_range(0, 15) == 0, $urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
